// File: rtl/apb3_cmd_master.sv
// APB3 initiator: turns a valid/ready command stream into SETUP/ACCESS transfers
// and returns read data / error status on a valid/ready response stream.
module apb3_cmd_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] wait_cnt;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
    end else begin
      case (state)
        IDLE: begin
          // cmd_ready comes up one edge after reset release, so the first
          // IDLE cycle out of reset never accepts.
          if (!cmd_ready) begin
            cmd_ready <= 1'b1;
          end else if (cmd_valid) begin
            cmd_ready <= 1'b0;
            PWRITE    <= cmd_write;
            PADDR     <= cmd_addr;
            PWDATA    <= cmd_wdata;
            PSEL      <= 1'b1;
            wait_cnt  <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else if (TO_EN && wait_cnt == TO_LAST) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else if (wait_cnt != 16'hFFFF) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb3_cmd_master.md
# apb3_cmd_master

APB3 initiator that converts a simple valid/ready command stream into APB3 SETUP/ACCESS transfers, then returns read data and error status on a valid/ready response stream. It sits between an internal controller (sequencer, debug bridge, boot loader) and an APB3 slave segment such as the CoreAPB3 fabric and its register slaves. It adds PREADY wait-state handling, PSLVERR capture and a bus-hang timeout.

## Interface
- ADDR_WIDTH, 32: PADDR / cmd_addr width (1–32).
- DATA_WIDTH, 32: PWDATA / PRDATA / cmd_wdata / rsp_rdata width (8, 16 or 32).
- TIMEOUT_CYCLES, 256: maximum ACCESS cycles with PREADY low before abort; 0 disables; 16-bit range (0–65535).

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESETN  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block accepts a command this cycle.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_wdata  in  DATA_WIDTH  write data; captured on every accept, including reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR was seen, or the transfer timed out.
- rsp_timeout  out  1  transfer aborted by timeout.
- PSEL, PENABLE, PWRITE  out  1  APB3 control.
- PADDR  out  ADDR_WIDTH  APB3 address.
- PWDATA  out  DATA_WIDTH  APB3 write data.
- PRDATA  in  DATA_WIDTH  APB3 read data.
- PREADY  in  1  slave ready.
- PSLVERR  in  1  slave error; sampled only when PREADY is high.

## Operation
- All outputs are registered.
- FSM states and transitions:
  - IDLE: cmd_ready=1. When cmd_valid is high, latch cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA, then go to SETUP.
  - SETUP: PSEL=1, PENABLE=0. Always go to ACCESS after one cycle.
  - ACCESS: PSEL=1, PENABLE=1.
    - If PREADY=1: capture rdata (PRDATA on reads, 0 on writes) and rsp_err=PSLVERR, set rsp_timeout=0, go to RESP.
    - Else if the wait counter has reached TIMEOUT_CYCLES−1 (TIMEOUT_CYCLES≠0): set rdata=0, rsp_err=1, rsp_timeout=1, go to RESP.
    - Otherwise increment the wait counter and stay in ACCESS.
  - RESP: PSEL=0, PENABLE=0, rsp_valid=1. Hold rsp_rdata, rsp_err and rsp_timeout stable until rsp_ready=1, then go to IDLE.
- cmd_ready is low in SETUP, ACCESS and RESP. Only one transfer is outstanding at a time.
- PADDR, PWRITE and PWDATA stay stable from SETUP until the next accept, including while idle.
- Wait counter: 16-bit. Cleared on entry to SETUP. Counts ACCESS cycles with PREADY low and never wraps.
- If PREADY goes high in the same cycle the terminal count is reached, the transfer completes normally (no timeout).
- PSLVERR is ignored on cycles where PREADY is low.
- After a timeout the bus is released (PSEL=0). A late PREADY from the slave is ignored.
- Reset, including mid-transfer: asynchronously force IDLE and drive every output to 0 (cmd_ready included). Any pending response is discarded and the wait counter is cleared. cmd_ready rises on the first PCLK edge after PRESETN deasserts.

## Timing
- Accept edge = cycle 0. SETUP occupies cycle 1 and ACCESS starts in cycle 2.
- With PREADY=1 in cycle 2, rsp_valid=1 in cycle 3.
- With N wait states, rsp_valid rises in cycle 3+N.
- With rsp_ready held at 1, RESP lasts 1 cycle and cmd_ready=1 again in cycle 4. Minimum issue interval is 4 cycles.
- Timeout response: rsp_valid rises TIMEOUT_CYCLES+2 cycles after the accept edge (PSEL drops in that same cycle).
- rsp_valid, once high, stays high with constant data until the rsp_ready handshake. cmd_ready stays low throughout.

## Test plan
- Zero-wait write, cmd_addr=0x0000_0010, cmd_wdata=0xDEAD_BEEF, PREADY tied to 1:
  - PSEL=1/PENABLE=0 in cycle 1, PSEL=1/PENABLE=1 in cycle 2, PADDR=0x10, PWDATA=0xDEADBEEF.
  - rsp_valid in cycle 3 with rsp_err=0 and rsp_rdata=0.
- Read with 3 wait states, PRDATA=0x1234_5678 on the completion cycle:
  - ACCESS lasts 4 cycles; rsp_valid in cycle 6; rsp_rdata=0x12345678; PADDR held stable throughout.
- PSLVERR handling:
  - Write with PSLVERR=1 while PREADY=0 for 2 cycles, then PSLVERR=1 with PREADY=1 → rsp_err=1, rsp_timeout=0.
  - Repeat with PSLVERR=0 at completion → rsp_err=0.
- Timeout, TIMEOUT_CYCLES=4, PREADY held at 0:
  - rsp_valid in cycle 6 with rsp_err=1, rsp_timeout=1, rsp_rdata=0; PSEL=0 from that cycle.
  - PREADY pulsed afterwards causes no change.
  - Separate run with PREADY=1 exactly in the 4th ACCESS cycle → normal completion.
- Response backpressure:
  - rsp_ready held at 0 for 5 cycles → rsp_valid and data stable for all 5, cmd_ready=0, and a cmd_valid held at 1 is not accepted.
  - Release rsp_ready → cmd_ready=1 the following cycle.
- Reset during ACCESS with PREADY=0:
  - PSEL, PENABLE, cmd_ready and rsp_valid go to 0 asynchronously.
  - After release, a new read completes normally and no stale response is produced.
